// File: rtl/code_lock_prog.sv
// Reprogrammable keypad code lock.
// Collects CODE_LEN digit strobes and compares them with a code register that
// can be rewritten while the lock is open. Consecutive mismatches lead to a
// timed lockout. A partial entry is dropped after ENTRY_TMO idle cycles, and
// the lock can optionally relock itself after AUTO_CLOSE open cycles.
module code_lock_prog #(
  parameter int DIGIT_W     = 4,
  parameter int CODE_LEN    = 4,
  parameter logic [DIGIT_W*CODE_LEN-1:0] DEFAULT_CODE = 16'h2327,
  parameter int MAX_FAIL    = 3,
  parameter int LOCKOUT_CYC = 1000,
  parameter int ENTRY_TMO   = 500,
  parameter int AUTO_CLOSE  = 0
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [DIGIT_W-1:0]            i_digit,
  input  logic                          i_digit_vld,
  input  logic                          i_close,
  input  logic                          i_prog,
  output logic                          o_open,
  output logic                          o_prog,
  output logic                          o_lockout,
  output logic [$clog2(MAX_FAIL+1)-1:0] o_fail_cnt
);

  localparam int CODE_W = DIGIT_W * CODE_LEN;
  localparam int CNT_W  = $clog2(CODE_LEN + 1);
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);
  localparam int LOCK_W = $clog2(LOCKOUT_CYC + 1);
  // Timers that can be disabled by a zero parameter still get one bit.
  localparam int IDLE_W = (ENTRY_TMO > 0) ? $clog2(ENTRY_TMO + 1) : 1;
  localparam int AUTO_W = (AUTO_CLOSE > 0) ? $clog2(AUTO_CLOSE + 1) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CODE_LEN - 1);
  localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_FAIL);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCKOUT_CYC - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((ENTRY_TMO > 0) ? ENTRY_TMO - 1 : 0);
  localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'((AUTO_CLOSE > 0) ? AUTO_CLOSE - 1 : 0);

  localparam logic [1:0] S_ENTRY = 2'd0;
  localparam logic [1:0] S_OPEN  = 2'd1;
  localparam logic [1:0] S_PROG  = 2'd2;
  localparam logic [1:0] S_LOCK  = 2'd3;

  logic [1:0]        state_reg, state_next;
  logic [CODE_W-1:0] code_reg, code_next;
  logic [CODE_W-1:0] buf_reg, buf_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [FAIL_W-1:0] fail_reg, fail_next;
  logic [IDLE_W-1:0] idle_reg, idle_next;
  logic [LOCK_W-1:0] lock_reg, lock_next;
  logic [AUTO_W-1:0] auto_reg, auto_next;
  logic              open_reg, prog_reg, lockout_reg;

  logic [CODE_W-1:0] shifted;
  logic [FAIL_W-1:0] fail_inc;
  logic              last_digit;

  // The buffer is cleared after every attempt, so shifting the full width
  // leaves exactly the digits of the current attempt in it.
  assign shifted    = (buf_reg << DIGIT_W) | CODE_W'(i_digit);
  assign last_digit = (cnt_reg == CNT_LAST);
  assign fail_inc   = (fail_reg == FAIL_MAX) ? fail_reg : fail_reg + 1'b1;

  // Next-state and datapath decisions for all four states.
  always_comb begin
    state_next = state_reg;
    code_next  = code_reg;
    buf_next   = buf_reg;
    cnt_next   = cnt_reg;
    fail_next  = fail_reg;
    idle_next  = idle_reg;
    lock_next  = lock_reg;
    auto_next  = auto_reg;
    case (state_reg)
      S_ENTRY: begin
        if (i_digit_vld) begin
          idle_next = '0;
          if (last_digit) begin
            buf_next = '0;
            cnt_next = '0;
            if (shifted == code_reg) begin
              state_next = S_OPEN;
              fail_next  = '0;
              auto_next  = '0;
            end else begin
              fail_next = fail_inc;
              if (fail_inc == FAIL_MAX) begin
                state_next = S_LOCK;
                lock_next  = '0;
              end
            end
          end else begin
            buf_next = shifted;
            cnt_next = cnt_reg + 1'b1;
          end
        end else if (ENTRY_TMO != 0 && cnt_reg != '0) begin
          // Abandoned partial entry: drop it without counting a failure.
          if (idle_reg == IDLE_LAST) begin
            buf_next  = '0;
            cnt_next  = '0;
            idle_next = '0;
          end else begin
            idle_next = idle_reg + 1'b1;
          end
        end
      end
      S_OPEN: begin
        if (i_close) begin
          state_next = S_ENTRY;
          auto_next  = '0;
        end else if (i_prog) begin
          state_next = S_PROG;
          auto_next  = '0;
          buf_next   = '0;
          cnt_next   = '0;
        end else if (AUTO_CLOSE != 0) begin
          if (auto_reg == AUTO_LAST) begin
            state_next = S_ENTRY;
            auto_next  = '0;
          end else begin
            auto_next = auto_reg + 1'b1;
          end
        end
      end
      S_PROG: begin
        // A close request wins even over a completing digit: nothing is committed.
        if (i_close) begin
          state_next = S_ENTRY;
          buf_next   = '0;
          cnt_next   = '0;
        end else if (i_digit_vld) begin
          if (last_digit) begin
            code_next  = shifted;
            state_next = S_OPEN;
            auto_next  = '0;
            buf_next   = '0;
            cnt_next   = '0;
          end else begin
            buf_next = shifted;
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      default: begin
        if (lock_reg == LOCK_LAST) begin
          state_next = S_ENTRY;
          fail_next  = '0;
          lock_next  = '0;
        end else begin
          lock_next = lock_reg + 1'b1;
        end
      end
    endcase
  end

  // State, code, counters and output flags update on the clock edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg   <= S_ENTRY;
      code_reg    <= DEFAULT_CODE;
      buf_reg     <= '0;
      cnt_reg     <= '0;
      fail_reg    <= '0;
      idle_reg    <= '0;
      lock_reg    <= '0;
      auto_reg    <= '0;
      open_reg    <= 1'b0;
      prog_reg    <= 1'b0;
      lockout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      code_reg    <= code_next;
      buf_reg     <= buf_next;
      cnt_reg     <= cnt_next;
      fail_reg    <= fail_next;
      idle_reg    <= idle_next;
      lock_reg    <= lock_next;
      auto_reg    <= auto_next;
      open_reg    <= (state_next == S_OPEN) || (state_next == S_PROG);
      prog_reg    <= (state_next == S_PROG);
      lockout_reg <= (state_next == S_LOCK);
    end
  end

  assign o_open     = open_reg;
  assign o_prog     = prog_reg;
  assign o_lockout  = lockout_reg;
  assign o_fail_cnt = fail_reg;

endmodule

// File: tb/tb_code_lock_prog.sv
// Bench for code_lock_prog: two instances (auto-relock off and AUTO_CLOSE=10)
// share one stimulus stream and are compared every cycle against a
// behavioural model built from countdowns, cycle stamps and integer codes.
module tb_code_lock_prog;

  localparam int DW  = 4;
  localparam int CL  = 4;
  localparam int MF  = 3;
  localparam int LC  = 8;
  localparam int ET  = 5;
  localparam int AC  = 10;
  localparam int DEF = 16'h2327;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] digit = '0;
  logic       vld = 1'b0;
  logic       close_req = 1'b0;
  logic       prog_req = 1'b0;

  logic       open0, prog0, lock0;
  logic [1:0] fail0;
  logic       open1, prog1, lock1;
  logic [1:0] fail1;

  always #5 clk = ~clk;

  code_lock_prog #(
    .DIGIT_W(DW), .CODE_LEN(CL), .DEFAULT_CODE(16'h2327), .MAX_FAIL(MF),
    .LOCKOUT_CYC(LC), .ENTRY_TMO(ET), .AUTO_CLOSE(0)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_digit(digit), .i_digit_vld(vld),
    .i_close(close_req), .i_prog(prog_req),
    .o_open(open0), .o_prog(prog0), .o_lockout(lock0), .o_fail_cnt(fail0)
  );

  code_lock_prog #(
    .DIGIT_W(DW), .CODE_LEN(CL), .DEFAULT_CODE(16'h2327), .MAX_FAIL(MF),
    .LOCKOUT_CYC(LC), .ENTRY_TMO(ET), .AUTO_CLOSE(AC)
  ) dut_ac (
    .i_clk(clk), .i_rst(rst), .i_digit(digit), .i_digit_vld(vld),
    .i_close(close_req), .i_prog(prog_req),
    .o_open(open1), .o_prog(prog1), .o_lockout(lock1), .o_fail_cnt(fail1)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Model state per instance: index 0 = no auto-relock, 1 = AUTO_CLOSE=10.
  int m_open[2], m_prog[2], m_lock_left[2], m_fails[2];
  int m_code[2], m_val[2], m_n[2], m_last[2], m_age[2];
  int ac_of[2] = '{0, AC};
  int digit_pool[6] = '{1, 2, 3, 5, 7, 9};

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_open[k] = 0; m_prog[k] = 0; m_lock_left[k] = 0; m_fails[k] = 0;
      m_code[k] = DEF; m_val[k] = 0; m_n[k] = 0; m_last[k] = 0; m_age[k] = 0;
    end
  endtask

  // One clock of the reference behaviour for instance k, using current inputs.
  task automatic model_step(input int k);
    if (m_lock_left[k] > 0) begin
      m_lock_left[k]--;
      if (m_lock_left[k] == 0) m_fails[k] = 0;
    end else if (m_prog[k] != 0) begin
      if (close_req) begin
        m_prog[k] = 0; m_open[k] = 0; m_val[k] = 0; m_n[k] = 0;
      end else if (vld) begin
        m_val[k] = m_val[k] * 16 + int'(digit);
        m_n[k]++;
        if (m_n[k] == CL) begin
          m_code[k] = m_val[k]; m_prog[k] = 0; m_age[k] = 0;
          m_val[k] = 0; m_n[k] = 0;
        end
      end
    end else if (m_open[k] != 0) begin
      if (close_req) m_open[k] = 0;
      else if (prog_req) begin
        m_prog[k] = 1; m_val[k] = 0; m_n[k] = 0;
      end else if (ac_of[k] != 0) begin
        m_age[k]++;
        if (m_age[k] == ac_of[k]) m_open[k] = 0;
      end
    end else begin
      if (vld) begin
        m_val[k] = m_val[k] * 16 + int'(digit);
        m_n[k]++;
        m_last[k] = cyc;
        if (m_n[k] == CL) begin
          if (m_val[k] == m_code[k]) begin
            m_open[k] = 1; m_fails[k] = 0; m_age[k] = 0;
          end else begin
            m_fails[k]++;
            if (m_fails[k] == MF) m_lock_left[k] = LC;
          end
          m_val[k] = 0; m_n[k] = 0;
        end
      end else if (m_n[k] > 0 && cyc - m_last[k] >= ET) begin
        m_val[k] = 0; m_n[k] = 0;
      end
    end
  endtask

  task automatic compare_all();
    check("open0", int'(open0), m_open[0]);
    check("prog0", int'(prog0), m_prog[0]);
    check("lock0", int'(lock0), int'(m_lock_left[0] > 0));
    check("fail0", int'(fail0), m_fails[0]);
    check("open1", int'(open1), m_open[1]);
    check("prog1", int'(prog1), m_prog[1]);
    check("lock1", int'(lock1), int'(m_lock_left[1] > 0));
    check("fail1", int'(fail1), m_fails[1]);
  endtask

  task automatic cycle(input int d, input bit v, input bit c, input bit p, input bit r);
    @(negedge clk);
    digit = 4'(d); vld = v; close_req = c; prog_req = p; rst = r;
    @(posedge clk);
    cyc++;
    if (r) model_reset();
    else for (int k = 0; k < 2; k++) model_step(k);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic key(input int d);
    cycle(d, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic enter_code(input int code);
    for (int i = CL - 1; i >= 0; i--) key((code >> (4 * i)) & 15);
  endtask

  task automatic do_close();
    cycle(0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_prog();
    cycle(0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    int r;
    model_reset();
    cycle(0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_open", int'(open0), 0);
    check("rst_fail", int'(fail0), 0);

    // Correct code with idle gaps of 0, 2 and 4 cycles, then close.
    key(2); key(3); idle(2); key(2); idle(4); key(7);
    check("t1_open", int'(open0), 1);
    do_close();
    check("t1_closed", int'(open0), 0);

    // Three wrong entries, lockout, ignored code, expiry, then open.
    enter_code(16'h1111);
    check("t2_fail1", int'(fail0), 1);
    enter_code(16'h1111);
    check("t2_fail2", int'(fail0), 2);
    enter_code(16'h1111);
    check("t2_lock", int'(lock0), 1);
    enter_code(16'h2327);
    idle(6);
    check("t2_unlock", int'(lock0), 0);
    enter_code(16'h2327);
    check("t2_open", int'(open0), 1);

    // Reprogram to 5555, old code fails, new code opens, reset restores default.
    do_prog();
    check("t3_prog", int'(prog0), 1);
    enter_code(16'h5555);
    check("t3_prog_done", int'(prog0), 0);
    check("t3_still_open", int'(open0), 1);
    do_close();
    enter_code(16'h2327);
    check("t3_old_fails", int'(fail0), 1);
    enter_code(16'h5555);
    check("t3_new_opens", int'(open0), 1);
    cycle(0, 1'b0, 1'b0, 1'b0, 1'b1);
    enter_code(16'h2327);
    check("t3_default_back", int'(open0), 1);
    do_close();

    // Timeout mid-entry, then a misaligned stream.
    key(2); key(3); idle(6);
    key(2); key(7); key(2); key(3);
    check("t4_fail", int'(fail0), 1);
    key(2); key(7);
    idle(6);

    // Abort programming, default kept; close+prog together goes to ENTRY.
    enter_code(16'h2327);
    do_prog(); key(9); key(9); do_close();
    check("t5_abort", int'(open0), 0);
    enter_code(16'h2327);
    check("t5_code_kept", int'(open0), 1);
    cycle(0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("t5_close_prio", int'(open0), 0);

    // Auto relock on the AUTO_CLOSE instance only.
    enter_code(16'h2327);
    idle(9);
    check("t6_open_9", int'(open1), 1);
    idle(1);
    check("t6_auto_closed", int'(open1), 0);
    check("t6_manual_open", int'(open0), 1);
    do_close();

    // Randomised traffic.
    for (int it = 0; it < 400; it++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2)       cycle(0, 1'b0, 1'b0, 1'b0, 1'b1);
      else if (r < 8)  do_close();
      else if (r < 14) do_prog();
      else if (r < 24) idle(int'($urandom_range(1, 7)));
      else if (r < 34) enter_code(m_code[0]);
      else if (r < 38) cycle(digit_pool[$urandom % 6], 1'b1, 1'b1, 1'b0, 1'b0);
      else             key(digit_pool[$urandom % 6]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
